// File: rtl/mips_ctrl_pkg.sv
// Shared definitions for the multicycle MIPS main control FSM.
// Holds opcode/func constants, the 3-bit alu_op codes (shared with the
// ALU control decoder), state encodings, mux encodings and the control
// vector struct produced by the output decoder.
package mips_ctrl_pkg;

  // Opcodes (IR[31:26])
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  // Function field (IR[5:0]) for jr
  localparam logic [5:0] FUNC_JR  = 6'b001000;

  // alu_op codes consumed by the ALU control decoder
  localparam logic [2:0] ALU_OP_MEM   = 3'b000;
  localparam logic [2:0] ALU_OP_BEQ   = 3'b001;
  localparam logic [2:0] ALU_OP_ARITH = 3'b010;
  localparam logic [2:0] ALU_OP_SLTI  = 3'b011;
  localparam logic [2:0] ALU_OP_BNE   = 3'b100;

  // alu_src_b encodings
  localparam logic [1:0] SRC_B_REG     = 2'b00;
  localparam logic [1:0] SRC_B_FOUR    = 2'b01;
  localparam logic [1:0] SRC_B_IMM     = 2'b10;
  localparam logic [1:0] SRC_B_IMM_SH2 = 2'b11;

  // pc_source encodings
  localparam logic [1:0] PC_SRC_ALU    = 2'b00;
  localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

  // FSM states; encodings 14-15 are unused and recover to FETCH
  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_MEM_RD   = 4'd3,
    S_MEM_WB   = 4'd4,
    S_MEM_WR   = 4'd5,
    S_R_EXEC   = 4'd6,
    S_R_WB     = 4'd7,
    S_BRANCH   = 4'd8,
    S_JUMP     = 4'd9,
    S_I_EXEC   = 4'd10,
    S_I_WB     = 4'd11,
    S_JR       = 4'd12,
    S_TRAP     = 4'd13
  } state_t;

  // Datapath control vector (pc_en is derived from it in the top)
  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic [1:0] pc_source;
  } ctrl_t;

endpackage

// File: rtl/mips_ctrl_outdec.sv
// Output decoder for the multicycle MIPS control FSM.
// Purely combinational: maps the current state (plus the latched opcode
// for branch/immediate flavours and mem_ready for the FETCH handshake)
// onto the datapath control vector.
//   state     : current FSM state
//   op_q      : opcode latched in DECODE
//   mem_ready : memory completes the access this cycle
//   ctrl      : control vector (all fields 0 unless listed for the state)
module mips_ctrl_outdec
  import mips_ctrl_pkg::*;
(
  input  state_t     state,
  input  logic [5:0] op_q,
  input  logic       mem_ready,
  output ctrl_t      ctrl
);

  always_comb begin
    ctrl        = '0;
    ctrl.alu_op = ALU_OP_MEM;
    case (state)
      S_FETCH: begin
        // PC+4 is computed every FETCH cycle but only committed, together
        // with the IR load, once memory returns the instruction.
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = SRC_B_FOUR;
        ctrl.pc_source = PC_SRC_ALU;
        ctrl.ir_write  = mem_ready;
        ctrl.pc_write  = mem_ready;
      end
      S_DECODE: begin
        // Speculatively compute the branch target into ALUOut.
        ctrl.alu_src_b = SRC_B_IMM_SH2;
      end
      S_MEM_ADDR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRC_B_IMM;
      end
      S_MEM_RD: begin
        ctrl.mem_read = 1'b1;
        ctrl.i_or_d   = 1'b1;
      end
      S_MEM_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
      end
      S_MEM_WR: begin
        ctrl.mem_write = 1'b1;
        ctrl.i_or_d    = 1'b1;
      end
      S_R_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRC_B_REG;
        ctrl.alu_op    = ALU_OP_ARITH;
      end
      S_R_WB: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = 1'b1;
      end
      S_BRANCH: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_src_b     = SRC_B_REG;
        ctrl.alu_op        = (op_q == OP_BNE) ? ALU_OP_BNE : ALU_OP_BEQ;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = PC_SRC_ALUOUT;
      end
      S_JUMP: begin
        ctrl.pc_write  = 1'b1;
        ctrl.pc_source = PC_SRC_JUMP;
      end
      S_I_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRC_B_IMM;
        ctrl.alu_op    = (op_q == OP_SLTI) ? ALU_OP_SLTI : ALU_OP_MEM;
      end
      S_I_WB: begin
        ctrl.reg_write = 1'b1;
      end
      S_JR: begin
        // rs + rt with rt=$0 passes rs straight through to the PC.
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRC_B_REG;
        ctrl.alu_op    = ALU_OP_ARITH;
        ctrl.pc_source = PC_SRC_ALU;
        ctrl.pc_write  = 1'b1;
      end
      default: ;  // TRAP and unused encodings: everything idle
    endcase
  end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Main control FSM of the multicycle MIPS core.
// Sequences fetch/decode/execute/memory/writeback, stalls on mem_ready,
// and traps (sticky illegal flag) on unsupported opcodes.
// Handshake: a memory access started by FETCH, MEM_RD or MEM_WR keeps its
// strobe asserted every cycle until the cycle in which mem_ready=1; that
// cycle completes the access and the FSM leaves the state at the next edge.
// Ports:
//   clk, rst_n            : clock, synchronous active-low reset
//   opcode, func, zero    : instruction fields and ALU zero flag
//   mem_ready             : memory access completes this cycle
//   pc_write..pc_source   : datapath controls (all 0 while rst_n=0)
//   illegal               : sticky unsupported-opcode flag
//   state_o               : current state for debug
module mips_multicycle_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [5:0]         opcode,
  input  logic [5:0]         func,
  input  logic               zero,
  input  logic               mem_ready,
  output logic               pc_write,
  output logic               pc_write_cond,
  output logic               pc_en,
  output logic               i_or_d,
  output logic               mem_read,
  output logic               mem_write,
  output logic               ir_write,
  output logic               mem_to_reg,
  output logic               reg_dst,
  output logic               reg_write,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [2:0]         alu_op,
  output logic [1:0]         pc_source,
  output logic               illegal,
  output logic [STATE_W-1:0] state_o
);

  state_t     state;
  logic [5:0] op_q;
  logic       illegal_q;
  ctrl_t      ctrl;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_FETCH;
      op_q      <= '0;
      illegal_q <= 1'b0;
    end else begin
      case (state)
        S_FETCH:    if (mem_ready) state <= S_DECODE;
        S_DECODE: begin
          op_q <= opcode;
          case (opcode)
            OP_LW, OP_SW:    state <= S_MEM_ADDR;
            OP_RTYPE:        state <= (func == FUNC_JR) ? S_JR : S_R_EXEC;
            OP_BEQ, OP_BNE:  state <= S_BRANCH;
            OP_ADDI, OP_SLTI: state <= S_I_EXEC;
            OP_J:            state <= S_JUMP;
            default:         state <= S_TRAP;
          endcase
        end
        S_MEM_ADDR: state <= (op_q == OP_LW) ? S_MEM_RD : S_MEM_WR;
        S_MEM_RD:   if (mem_ready) state <= S_MEM_WB;
        S_MEM_WR:   if (mem_ready) state <= S_FETCH;
        S_R_EXEC:   state <= S_R_WB;
        S_I_EXEC:   state <= S_I_WB;
        S_MEM_WB, S_R_WB, S_I_WB, S_BRANCH, S_JUMP, S_JR:
                    state <= S_FETCH;
        S_TRAP:     illegal_q <= 1'b1;  // absorbing until reset
        default:    state <= S_FETCH;
      endcase
    end
  end

  mips_ctrl_outdec u_outdec (
    .state     (state),
    .op_q      (op_q),
    .mem_ready (mem_ready),
    .ctrl      (ctrl)
  );

  // Outputs are held at 0 while reset is asserted so an abandoned
  // instruction cannot fire a write strobe in the reset cycle.
  assign pc_write      = rst_n & ctrl.pc_write;
  assign pc_write_cond = rst_n & ctrl.pc_write_cond;
  assign pc_en         = rst_n & (ctrl.pc_write | (ctrl.pc_write_cond & zero));
  assign i_or_d        = rst_n & ctrl.i_or_d;
  assign mem_read      = rst_n & ctrl.mem_read;
  assign mem_write     = rst_n & ctrl.mem_write;
  assign ir_write      = rst_n & ctrl.ir_write;
  assign mem_to_reg    = rst_n & ctrl.mem_to_reg;
  assign reg_dst       = rst_n & ctrl.reg_dst;
  assign reg_write     = rst_n & ctrl.reg_write;
  assign alu_src_a     = rst_n & ctrl.alu_src_a;
  assign alu_src_b     = rst_n ? ctrl.alu_src_b : 2'b00;
  assign alu_op        = rst_n ? ctrl.alu_op    : 3'b000;
  assign pc_source     = rst_n ? ctrl.pc_source : 2'b00;
  assign illegal       = rst_n & illegal_q;
  assign state_o       = STATE_W'(state);

endmodule
